// File: rtl/pattern_buffer_bank.sv
// pattern_buffer_bank: NUM_BUFS pattern buffers of DEPTH fields, WIDTH bits per field.
// Fields are loaded serially (sclk/sin/ssel, sampled on clk) or written directly at the
// buffer/field pointers. A direct write wins over a serial commit to the same entry.
// Optional macro PATBUF_READBACK_EN adds serial readback of mem[saddr][ld_ptr] on sout.
module pattern_buffer_bank #(
    parameter int unsigned NUM_BUFS = 8,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned WIDTH    = 8,
    localparam int unsigned BW      = $clog2(NUM_BUFS),
    localparam int unsigned FW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             sin,
    input  logic             ssel,
    input  logic [BW-1:0]    saddr,
    output logic             sout,
    input  logic [BW-1:0]    bufp_in,
    input  logic             bufp_load,
    input  logic [FW-1:0]    fieldp_in,
    input  logic             fieldp_load,
    input  logic             fieldp_inc,
    input  logic [WIDTH-1:0] field_in,
    input  logic             field_write,
    output logic [WIDTH-1:0] field_byte,
    output logic             field_wrap,
    output logic             load_done,
    output logic             load_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    // Synchroniser stages; r_sclk_d holds the previous synchronised sclk for edge detection
    logic r_sclk_meta, r_sclk_s, r_sclk_d;
    logic r_sin_meta, r_sin_s;
    logic r_ssel_meta, r_ssel_s;

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_bitcnt;
    logic [FW-1:0]    r_ld_ptr;
    logic             r_load_done;
    logic             r_load_err;

    logic [BW-1:0]    r_bufp;
    logic [FW-1:0]    r_fieldp;
    logic             r_field_wrap;

    logic [WIDTH-1:0] r_mem [NUM_BUFS][DEPTH];
    logic [WIDTH-1:0] r_field_byte;

    logic w_rise;
    logic w_commit;
    logic w_conflict;

    assign w_rise     = r_sclk_s & ~r_sclk_d;
    // A full field is pending; it is committed at this edge
    assign w_commit   = r_ssel_s && (r_bitcnt == CW'(WIDTH));
    assign w_conflict = w_commit && field_write && (saddr == r_bufp) && (r_ld_ptr == r_fieldp);

    // Two-flop synchronisers for the serial pins plus the sclk edge-detect stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_s    <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_sin_meta  <= 1'b0;
            r_sin_s     <= 1'b0;
            r_ssel_meta <= 1'b0;
            r_ssel_s    <= 1'b0;
        end else begin
            r_sclk_meta <= sclk;
            r_sclk_s    <= r_sclk_meta;
            r_sclk_d    <= r_sclk_s;
            r_sin_meta  <= sin;
            r_sin_s     <= r_sin_meta;
            r_ssel_meta <= ssel;
            r_ssel_s    <= r_ssel_meta;
        end
    end

    // Serial shifter, bit counter and load pointer; deselect discards any partial field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_ld_ptr <= '0;
        end else if (!r_ssel_s) begin
            r_bitcnt <= '0;
            r_ld_ptr <= '0;
        end else begin
            if (w_rise) begin
                r_sr     <= {r_sr[WIDTH-2:0], r_sin_s};
                r_bitcnt <= w_commit ? CW'(1) : r_bitcnt + 1'b1;
            end else if (w_commit) begin
                r_bitcnt <= '0;
            end
            if (w_commit) begin
                r_ld_ptr <= r_ld_ptr + 1'b1;
            end
        end
    end

    // Commit status pulses: done on a clean commit, err when a direct write claimed the entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_done <= w_commit && !w_conflict;
            r_load_err  <= w_conflict;
        end
    end

    // Buffer/field pointers: bufp_load over fieldp_load over fieldp_inc, one action per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bufp       <= '0;
            r_fieldp     <= '0;
            r_field_wrap <= 1'b0;
        end else begin
            r_field_wrap <= 1'b0;
            if (bufp_load) begin
                r_bufp <= bufp_in;
            end else if (fieldp_load) begin
                r_fieldp <= fieldp_in;
            end else if (fieldp_inc) begin
                r_fieldp     <= r_fieldp + 1'b1;
                r_field_wrap <= (r_fieldp == FW'(DEPTH - 1));
            end
        end
    end

    // Storage and read register; reads see pre-edge contents, direct write overrides serial
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < int'(NUM_BUFS); b++) begin
                for (int f = 0; f < int'(DEPTH); f++) begin
                    r_mem[b][f] <= '0;
                end
            end
            r_field_byte <= '0;
        end else begin
            r_field_byte <= r_mem[r_bufp][r_fieldp];
            if (w_commit && !w_conflict) begin
                r_mem[saddr][r_ld_ptr] <= r_sr;
            end
            if (field_write) begin
                r_mem[r_bufp][r_fieldp] <= field_in;
            end
        end
    end

`ifdef PATBUF_READBACK_EN
    logic [WIDTH-1:0] r_rb;
    logic             w_fall;

    assign w_fall = ~r_sclk_s & r_sclk_d;

    // Readback register: reload at field start, shift out MSB first on each serial fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb <= '0;
        end else if (r_ssel_s && (r_bitcnt == '0)) begin
            r_rb <= r_mem[saddr][r_ld_ptr];
        end else if (w_fall) begin
            r_rb <= {r_rb[WIDTH-2:0], 1'b0};
        end
    end

    assign sout = r_rb[WIDTH-1];
`else
    assign sout = 1'b0;
`endif

    assign field_byte = r_field_byte;
    assign field_wrap = r_field_wrap;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_pattern_buffer_bank.sv
// Directed bench for pattern_buffer_bank (default parameters 8 x 32 x 8).
// Readback sequence is checked against 0x81 when PATBUF_READBACK_EN is defined, else sout=0.
module tb_pattern_buffer_bank;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       sin;
    logic       ssel;
    logic [2:0] saddr;
    logic       sout;
    logic [2:0] bufp_in;
    logic       bufp_load;
    logic [4:0] fieldp_in;
    logic       fieldp_load;
    logic       fieldp_inc;
    logic [7:0] field_in;
    logic       field_write;
    logic [7:0] field_byte;
    logic       field_wrap;
    logic       load_done;
    logic       load_err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int wrap_cnt = 0;

    pattern_buffer_bank dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .sin         (sin),
        .ssel        (ssel),
        .saddr       (saddr),
        .sout        (sout),
        .bufp_in     (bufp_in),
        .bufp_load   (bufp_load),
        .fieldp_in   (fieldp_in),
        .fieldp_load (fieldp_load),
        .fieldp_inc  (fieldp_inc),
        .field_in    (field_in),
        .field_write (field_write),
        .field_byte  (field_byte),
        .field_wrap  (field_wrap),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters
    always @(posedge clk) begin
        if (load_done)  done_cnt++;
        if (load_err)   err_cnt++;
        if (field_wrap) wrap_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ptr(input int b, input int f);
        bufp_in = 3'(b);
        bufp_load = 1'b1;
        tick();
        bufp_load = 1'b0;
        fieldp_in = 5'(f);
        fieldp_load = 1'b1;
        tick();
        fieldp_load = 1'b0;
    endtask

    task automatic read_at(input int b, input int f, output logic [7:0] d);
        set_ptr(b, f);
        tick();
        d = field_byte;
    endtask

    task automatic write_at(input int b, input int f, input logic [7:0] d);
        set_ptr(b, f);
        field_in = d;
        field_write = 1'b1;
        tick();
        field_write = 1'b0;
    endtask

    // Shift one byte MSB first; optionally pulse field_write on the commit edge
    task automatic send_byte(input logic [7:0] b, input bit coincide, input logic [7:0] wd);
        for (int i = 7; i >= 0; i--) begin
            sin = b[i];
            sclk = 1'b0;
            repeat (4) tick();
            sclk = 1'b1;
            if (i == 0 && coincide) begin
                repeat (3) tick();
                field_in = wd;
                field_write = 1'b1;
                tick();
                field_write = 1'b0;
            end else begin
                repeat (4) tick();
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rb_exp;
        int w0;

        rst_n = 1'b1;
        sclk = 1'b0; sin = 1'b0; ssel = 1'b0; saddr = '0;
        bufp_in = '0; bufp_load = 1'b0;
        fieldp_in = '0; fieldp_load = 1'b0; fieldp_inc = 1'b0;
        field_in = '0; field_write = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_field_byte", 32'(field_byte), 32'h0);
        check("rst_sout", 32'(sout), 32'h0);
        check("rst_field_wrap", 32'(field_wrap), 32'h0);
        check("rst_load_done", 32'(load_done), 32'h0);
        check("rst_load_err", 32'(load_err), 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Whole memory reads zero after reset
        for (int b = 0; b < 8; b++) begin
            for (int f = 0; f < 32; f++) begin
                read_at(b, f, rd);
                check($sformatf("mem_clear[%0d][%0d]", b, f), 32'(rd), 32'h0);
            end
        end

        // Two serial bytes into buffer 3
        saddr = 3'd3;
        ssel = 1'b1;
        repeat (4) tick();
        send_byte(8'hA5, 1'b0, 8'h00);
        check("load_done_pulse", 32'(load_done), 32'h1);
        send_byte(8'h3C, 1'b0, 8'h00);
        sclk = 1'b0;
        repeat (6) tick();
        ssel = 1'b0;
        repeat (4) tick();
        check("load_done_count2", 32'(done_cnt), 32'd2);
        read_at(3, 0, rd);
        check("serial_3_0", 32'(rd), 32'hA5);
        read_at(3, 1, rd);
        check("serial_3_1", 32'(rd), 32'h3C);
        read_at(3, 2, rd);
        check("serial_3_2", 32'(rd), 32'h00);

        // Partial byte discarded on deselect, next byte starts clean
        saddr = 3'd4;
        ssel = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            sin = 1'b1;
            sclk = 1'b0;
            repeat (4) tick();
            sclk = 1'b1;
            repeat (4) tick();
        end
        sclk = 1'b0;
        repeat (4) tick();
        ssel = 1'b0;
        repeat (6) tick();
        ssel = 1'b1;
        repeat (4) tick();
        send_byte(8'h5A, 1'b0, 8'h00);
        sclk = 1'b0;
        repeat (6) tick();
        ssel = 1'b0;
        repeat (4) tick();
        check("load_done_count3", 32'(done_cnt), 32'd3);
        read_at(4, 0, rd);
        check("partial_discard", 32'(rd), 32'h5A);
        read_at(4, 1, rd);
        check("partial_no_extra", 32'(rd), 32'h00);

        // Read-before-write timing
        set_ptr(7, 7);
        tick();
        field_in = 8'hC3;
        field_write = 1'b1;
        tick();
        field_write = 1'b0;
        check("rbw_old", 32'(field_byte), 32'h00);
        tick();
        check("rbw_new", 32'(field_byte), 32'hC3);

        // Write uses pre-update pointers
        set_ptr(6, 2);
        field_in = 8'h62;
        field_write = 1'b1;
        fieldp_in = 5'd3;
        fieldp_load = 1'b1;
        tick();
        field_write = 1'b0;
        fieldp_load = 1'b0;
        read_at(6, 2, rd);
        check("write_pre_ptr", 32'(rd), 32'h62);
        read_at(6, 3, rd);
        check("write_not_post_ptr", 32'(rd), 32'h00);

        // Pointer priority
        write_at(6, 1, 8'h61);
        write_at(5, 1, 8'h51);
        set_ptr(5, 1);
        bufp_in = 3'd6;
        bufp_load = 1'b1;
        fieldp_inc = 1'b1;
        tick();
        bufp_load = 1'b0;
        fieldp_inc = 1'b0;
        tick();
        check("bufp_over_inc", 32'(field_byte), 32'h61);
        fieldp_in = 5'd9;
        fieldp_load = 1'b1;
        fieldp_inc = 1'b1;
        tick();
        fieldp_load = 1'b0;
        fieldp_inc = 1'b0;
        tick();
        check("fload_over_inc", 32'(field_byte), 32'h00);

        // Field pointer wrap
        write_at(5, 31, 8'hE1);
        write_at(5, 0, 8'h0F);
        set_ptr(5, 31);
        w0 = wrap_cnt;
        fieldp_inc = 1'b1;
        tick();
        fieldp_inc = 1'b0;
        check("wrap_pulse", 32'(field_wrap), 32'h1);
        check("wrap_read_31", 32'(field_byte), 32'hE1);
        tick();
        check("wrap_pulse_end", 32'(field_wrap), 32'h0);
        check("wrap_fieldp0", 32'(field_byte), 32'h0F);
        fieldp_inc = 1'b1;
        tick();
        fieldp_inc = 1'b0;
        check("no_wrap_pulse", 32'(field_wrap), 32'h0);
        tick();
        check("inc_fieldp1", 32'(field_byte), 32'h51);
        check("wrap_count", 32'(wrap_cnt - w0), 32'd1);

        // Commit alongside a write to another entry, then a colliding commit
        set_ptr(0, 9);
        saddr = 3'd2;
        ssel = 1'b1;
        repeat (4) tick();
        send_byte(8'h20, 1'b0, 8'h00);
        send_byte(8'h21, 1'b0, 8'h00);
        send_byte(8'h22, 1'b0, 8'h00);
        send_byte(8'h23, 1'b0, 8'h00);
        send_byte(8'h24, 1'b1, 8'h09);
        check("diff_entry_done", 32'(load_done), 32'h1);
        check("diff_entry_no_err", 32'(load_err), 32'h0);
        set_ptr(2, 5);
        send_byte(8'h11, 1'b1, 8'h77);
        check("conflict_err", 32'(load_err), 32'h1);
        check("conflict_no_done", 32'(load_done), 32'h0);
        send_byte(8'h12, 1'b0, 8'h00);
        sclk = 1'b0;
        repeat (6) tick();
        ssel = 1'b0;
        repeat (4) tick();
        read_at(2, 5, rd);
        check("conflict_write_wins", 32'(rd), 32'h77);
        read_at(2, 4, rd);
        check("diff_entry_serial", 32'(rd), 32'h24);
        read_at(0, 9, rd);
        check("diff_entry_direct", 32'(rd), 32'h09);
        read_at(2, 6, rd);
        check("ldptr_advanced", 32'(rd), 32'h12);
        check("load_done_total", 32'(done_cnt), 32'd9);
        check("load_err_total", 32'(err_cnt), 32'd1);

        // Serial readback of mem[1][0]
`ifdef PATBUF_READBACK_EN
        rb_exp = 8'h81;
`else
        rb_exp = 8'h00;
`endif
        write_at(1, 0, 8'h81);
        saddr = 3'd1;
        ssel = 1'b1;
        repeat (4) tick();
        for (int i = 7; i >= 0; i--) begin
            sin = 1'b0;
            sclk = 1'b0;
            repeat (4) tick();
            check($sformatf("sout_bit%0d", i), 32'(sout), 32'(rb_exp[i]));
            sclk = 1'b1;
            repeat (4) tick();
        end
        sclk = 1'b0;
        repeat (4) tick();
        ssel = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
